// File: rtl/pipe_seg_adder_pkg.sv
// Shared definitions for the segmented pipelined add/subtract unit:
// operation mode encodings and the operand/segment width legality check.
package pipe_seg_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width must split into 1..16 equal segments.
  function automatic bit width_ok(input int width, input int seg_w);
    return (seg_w > 0) && (width % seg_w == 0) &&
           (width / seg_w >= 1) && (width / seg_w <= 16);
  endfunction

endpackage

// File: rtl/pipe_seg_adder_stage.sv
// One pipeline stage: adds a SEG_W-bit operand slice plus the incoming carry
// and registers valid, carry-out and the slice sum when enabled.
module pipe_seg_adder_stage #(
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             v_i,
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             c_i,
  output logic             v_o,
  output logic [SEG_W-1:0] s_o,
  output logic             c_o
);

  logic [SEG_W:0] tot;

  always_comb begin
    tot = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, c_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_o <= 1'b0;
      s_o <= '0;
      c_o <= 1'b0;
    end else if (en) begin
      v_o <= v_i;
      s_o <= tot[SEG_W-1:0];
      c_o <= tot[SEG_W];
    end
  end

endmodule

// File: rtl/pipe_seg_adder.sv
// Pipelined add/subtract: one SEG_W segment per stage, carry registered between
// stages, operand buffers skew inputs forward and result buffers collect low segments.
module pipe_seg_adder
  import pipe_seg_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int NB   = (NSEG > 1) ? NSEG - 1 : 1;

  if (!width_ok(WIDTH, SEG_W)) begin : g_bad_width
    $error("pipe_seg_adder: WIDTH must be a multiple of SEG_W with 1..16 segments");
  end

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // The whole pipe advances together; it freezes only while a result is offered
  // and not taken, so in_ready never depends on in_valid.
  logic                          stall;
  logic                          en;
  logic [WIDTH-1:0]              b_eff;
  logic                          c_eff;
  logic [NSEG-1:0]               v_in, c_in, v_st, c_st;
  logic [NSEG-1:0][SEG_W-1:0]    a_seg, b_seg, s_st;
  logic [NB-1:0][WIDTH-1:0]      a_q, b_q, hold;
  logic [NSEG:1][WIDTH-1:0]      w;
  logic                          ab_msb;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  // Subtraction is a + ~b + ~cin, so cout=1 means no borrow.
  assign b_eff = (sub == MODE_SUB) ? ~b : b;
  assign c_eff = (sub == MODE_SUB) ? ~cin : cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_seg[0] = a[SEG_W-1:0];
      assign b_seg[0] = b_eff[SEG_W-1:0];
      assign v_in[0]  = in_valid;
      assign c_in[0]  = c_eff;
      assign w[1]     = WIDTH'(s_st[0]);
    end else begin : g_next
      assign a_seg[k] = a_q[k-1][k*SEG_W +: SEG_W];
      assign b_seg[k] = b_q[k-1][k*SEG_W +: SEG_W];
      assign v_in[k]  = v_st[k-1];
      assign c_in[k]  = c_st[k-1];
      // w[k+1] holds result segments 0..k of the transaction leaving stage k.
      assign w[k+1]   = hold[k-1] | (WIDTH'(s_st[k]) << (k * SEG_W));
    end

    pipe_seg_adder_stage #(.SEG_W(SEG_W)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .v_i   (v_in[k]),
      .a_i   (a_seg[k]),
      .b_i   (b_seg[k]),
      .c_i   (c_in[k]),
      .v_o   (v_st[k]),
      .s_o   (s_st[k]),
      .c_o   (c_st[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      hold   <= '0;
      ab_msb <= 1'b0;
    end else if (en) begin
      a_q[0]  <= a;
      b_q[0]  <= b_eff;
      hold[0] <= w[1];
      for (int j = 1; j < NB; j++) begin
        a_q[j]  <= a_q[j-1];
        b_q[j]  <= b_q[j-1];
        hold[j] <= w[j+1];
      end
      // Carry into the MSB is recovered later as a_msb ^ b_msb ^ sum_msb.
      ab_msb <= a_seg[NSEG-1][SEG_W-1] ^ b_seg[NSEG-1][SEG_W-1];
    end
  end

  assign out_valid = v_st[NSEG-1];
  assign sum       = w[NSEG];
  assign cout      = c_st[NSEG-1];
  assign ovf       = cout ^ ab_msb ^ sum[WIDTH-1];

endmodule

// File: tb/tb_pipe_seg_adder.sv
// Directed bench for pipe_seg_adder (WIDTH=64, SEG_W=16): reset, add/sub corner
// vectors with latency, backpressure ordering and asynchronous mid-flight reset.
module tb_pipe_seg_adder;

  localparam int WIDTH = 64;
  localparam int SEG_W = 16;
  localparam int NSEG  = WIDTH / SEG_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH+1:0] exp_q[$];

  pipe_seg_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [WIDTH+1:0] obs, input logic [WIDTH+1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic ci, input logic sb);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = ci;
    sub      = sb;
  endtask

  // Called at a negedge with out_ready=1; checks latency, result and no duplicate.
  task automatic single_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic ci, input logic sb, input logic [WIDTH-1:0] es,
                           input logic ec, input logic eo);
    drive(1'b1, av, bv, ci, sb);
    for (int i = 1; i <= NSEG; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (i < NSEG) chk({tag, "_early_valid"}, out_valid, 0);
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(negedge clk);
    chk({tag, "_no_dup"}, out_valid, 0);
  endtask

  // Backpressure stream: even ops add 1 across three all-ones segments,
  // odd ops subtract 1 borrowing across three zero segments.
  function automatic logic [WIDTH-1:0] bp_a(input int i);
    return (i % 2 == 0) ? {16'(i), 48'hFFFF_FFFF_FFFF} : {16'(i), 48'h0};
  endfunction

  function automatic logic [WIDTH+1:0] bp_exp(input int i);
    return (i % 2 == 0) ? {1'b0, 1'b0, 16'(i + 1), 48'h0}
                        : {1'b1, 1'b0, 16'(i - 1), 48'hFFFF_FFFF_FFFF};
  endfunction

  initial begin
    int sent;
    int recv;
    int cyc;
    int seen;
    logic [WIDTH+1:0] head;

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic vectors
    single_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    single_op("sub_neg", 64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    single_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1);
    single_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    single_op("sub_borrow_in", 64'h0, 64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    single_op("add_seg_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
              64'h0000_0000_0001_0000, 1'b0, 1'b0);
    single_op("add_cin_chain", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
              64'h2222_2222_2222_2212, 1'b0, 1'b0);

    // Backpressure: 8 back-to-back ops, out_ready low in cycles 5..7
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 8 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (sent < 8) drive(1'b1, bp_a(sent), 64'h1, 1'b0, (sent % 2 == 1));
      else in_valid = 1'b0;
      #1;
      chk("bp_in_ready", in_ready, (cyc >= 5 && cyc <= 7) ? 0 : 1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra_output", out_valid, 0);
        end else if (out_ready) begin
          head = exp_q.pop_front();
          chk("bp_result", {cout, ovf, sum}, head);
          recv++;
        end else begin
          chk("bp_hold", {cout, ovf, sum}, exp_q[0]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(bp_exp(sent));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_recv_count", recv, 8);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Asynchronous reset while a result is stalled at the output
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 64'h10, 64'h20, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post_rst_no_output", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
